// File: rtl/bp_stim_scorer.sv
// rtl/bp_stim_scorer.sv - branch-outcome stimulus generator and prediction scorer for a branch predictor.
// Optional miss-streak tracking is enabled by defining BP_STIM_STREAK_EN.
module bp_stim_scorer #(
  parameter int          NUM_BR    = 64,
  parameter int          LOOP_N    = 4,
  parameter int          THRESH    = 8,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [3:0] pred_in,
  output logic       jump,
  output logic       busy,
  output logic       done,
  output logic [7:0] hit_cnt,
  output logic [7:0] miss_cnt,
  output logic [7:0] max_streak
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0] LAST_IDX  = 8'(NUM_BR - 1);
  localparam logic [3:0] LOOP_LAST = 4'(LOOP_N - 1);
  localparam logic [3:0] TH        = 4'(THRESH);

  state_t     state;
  logic [1:0] mode_q;
  logic [7:0] idx;
  logic [3:0] loop_cnt;
  logic [7:0] lfsr;

  logic       correct;
  logic       first_jump;
  logic       jump_nxt;
  logic [3:0] loop_nxt;
  logic [7:0] lfsr_nxt;

  // Generator state always describes the outcome currently on jump.
  always_comb begin
    correct    = ((pred_in >= TH) == jump);
    loop_nxt   = (loop_cnt == LOOP_LAST) ? 4'd0 : loop_cnt + 4'd1;
    lfsr_nxt   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    first_jump = (mode == 2'd2) ? LFSR_SEED[0] : 1'b1;
    case (mode_q)
      2'd0:    jump_nxt = (loop_nxt != LOOP_LAST);
      2'd1:    jump_nxt = ~jump;
      2'd2:    jump_nxt = lfsr_nxt[0];
      default: jump_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mode_q   <= 2'd0;
      jump     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hit_cnt  <= 8'd0;
      miss_cnt <= 8'd0;
      idx      <= 8'd0;
      loop_cnt <= 4'd0;
      lfsr     <= LFSR_SEED;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            mode_q   <= mode;
            hit_cnt  <= 8'd0;
            miss_cnt <= 8'd0;
            idx      <= 8'd0;
            loop_cnt <= 4'd0;
            lfsr     <= LFSR_SEED;
            jump     <= first_jump;
          end
        end
        RUN: begin
          if (correct) hit_cnt  <= hit_cnt + 8'd1;
          else         miss_cnt <= miss_cnt + 8'd1;
          if (idx == LAST_IDX) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            jump  <= 1'b0;
          end else begin
            idx      <= idx + 8'd1;
            loop_cnt <= loop_nxt;
            lfsr     <= lfsr_nxt;
            jump     <= jump_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BP_STIM_STREAK_EN
  logic [7:0] streak;
  logic [7:0] streak_inc;

  always_comb streak_inc = (streak == 8'hFF) ? streak : streak + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak     <= 8'd0;
      max_streak <= 8'd0;
    end else if (state != RUN) begin
      if (start) begin
        streak     <= 8'd0;
        max_streak <= 8'd0;
      end
    end else if (correct) begin
      streak <= 8'd0;
    end else begin
      streak <= streak_inc;
      if (streak_inc > max_streak) max_streak <= streak_inc;
    end
  end
`else
  assign max_streak = 8'd0;
`endif

endmodule

// File: doc/bp_stim_scorer.md
Name: bp_stim_scorer

Overview:
- Outcome-side partner of the branch predictor (BP).
- Generates the per-cycle branch-outcome stream `jump` that BP consumes, and reads back BP's 4-bit `out` to score each prediction.
- Reports hit/miss totals and a done pulse, so a predictor can be exercised and graded on-chip without file-driven patterns.

Parameters:
- NUM_BR, 64, number of branch outcomes issued per run (1..255).
- LOOP_N, 4, loop-pattern period: LOOP_N-1 taken then 1 not-taken (2..15).
- THRESH, 8, predictor reads as "predict taken" when pred_in >= THRESH (unsigned 4-bit compare).
- LFSR_SEED, 8'hA5, reset/start seed of the random-mode LFSR (must be nonzero).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; ignored unless in IDLE or DONE.
- mode  in  2  pattern select, sampled on the accepted start: 0 loop, 1 alternate (T,N,T,...), 2 LFSR, 3 always-taken.
- pred_in  in  4  BP `out`, current prediction state.
- jump  out  1  branch outcome to BP, valid while busy.
- busy  out  1  high during RUN.
- done  out  1  one-cycle pulse after the last outcome is scored.
- hit_cnt  out  8  correct predictions in the current/last run.
- miss_cnt  out  8  wrong predictions in the current/last run.
- max_streak  out  8  longest consecutive-miss run; see Optional Feature.

Behaviour:
- Reset (async, any state): state=IDLE; jump=0, busy=0, done=0, hit_cnt=0, miss_cnt=0, max_streak=0; idx=0; loop counter=0; LFSR=LFSR_SEED.
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --(idx==NUM_BR-1 scored)--> DONE.
  - DONE --start--> RUN; otherwise stays in DONE.
- Run start:
  - Accepted start clears hit_cnt, miss_cnt, idx, loop counter and max_streak, reloads the LFSR with LFSR_SEED and latches mode.
  - busy rises on the next edge.
  - First outcome appears on jump in the cycle after start (1-cycle latency).
- RUN, each cycle:
  - jump is registered and holds outcome idx for the whole cycle.
  - At the rising edge ending that cycle, pred = (pred_in >= THRESH).
  - pred==jump increments hit_cnt, else miss_cnt.
  - The outcome generator then advances and idx increments.
  - BP sees the same jump at that same edge, so pred_in is always the prediction made before that outcome's update.
- Patterns:
  - Loop: taken while loop counter < LOOP_N-1, not-taken when it equals LOOP_N-1, then the counter wraps to 0.
  - Alternate: first outcome taken.
  - LFSR: 8-bit Fibonacci, taps 8,6,5,4, jump = LFSR[0], shift once per outcome.
  - Always-taken: jump=1.
- Completion:
  - After outcome NUM_BR-1 is scored: busy=0 and done=1 for exactly one cycle, then jump=0.
  - Counters hold their values in DONE until the next accepted start.
- start during RUN is ignored; the run is not restarted.
- Invariant after every run: hit_cnt + miss_cnt == NUM_BR. Counters never wrap, since NUM_BR ≤ 255.
- rst asserted mid-run aborts immediately to reset values; no done pulse is issued.
- mode changes during RUN have no effect; only the latched mode is used.
- pred_in is used only during RUN and is never stored while IDLE or DONE.

Optional Feature:
- Macro: BP_STIM_STREAK_EN.
- Defined:
  - An internal 8-bit current-miss-streak counter increments on each miss and clears on each hit; it saturates at 255.
  - max_streak updates to the current streak whenever it is exceeded, in the same edge.
  - max_streak holds its value in DONE and clears on start.
- Undefined: the streak logic is absent and max_streak is tied to 0.

Test Plan:
- Reset mid-run: assert rst at outcome 10 -> busy=0, jump=0, counters=0 within the same cycle; no done pulse; a fresh start afterwards gives a full NUM_BR-outcome run.
- Mode 3 with pred_in tied to 4'hF -> jump=1 for 64 cycles; hit_cnt=64, miss_cnt=0; done pulses once, exactly 64 cycles after busy rises.
- Mode 1 with pred_in tied to 4'h0 -> jump sequence 1,0,1,0,...; hit_cnt=32, miss_cnt=32; max_streak=1 with BP_STIM_STREAK_EN defined, 0 without.
- Mode 0 (LOOP_N=4) with pred_in tied to 4'h8 -> jump pattern 1,1,1,0 repeating; hit_cnt=48, miss_cnt=16.
- Mode 2 connected to the real BP with pattern checking -> jump stream equals the LFSR sequence from seed A5; hit_cnt+miss_cnt=64; a second start reproduces identical counts.
- start pulsed during RUN and mode toggled mid-run -> run length stays 64; the pattern is unchanged; only one done pulse.
